// File: rtl/ex_mem_wb_stage_if.sv
// Execute-to-memory bundle: live flag, flush, operands and controls.
// The execute stage drives it (master); the memory stage samples it.
interface ex_mem_wb_stage_if;
    logic        ex_valid;
    logic        flush;
    logic [31:0] pc_branch;
    logic        alu_zero;
    logic [31:0] alu_res;
    logic [4:0]  write_reg;
    logic [31:0] rt_data;
    logic        branch;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;

    modport master (
        output ex_valid, flush, pc_branch, alu_zero, alu_res,
        output write_reg, rt_data, branch, mem_read, mem_write,
        output reg_write, mem_to_reg
    );

    modport slave (
        input ex_valid, flush, pc_branch, alu_zero, alu_res,
        input write_reg, rt_data, branch, mem_read, mem_write,
        input reg_write, mem_to_reg
    );
endinterface

// File: rtl/ex_mem_wb_stage.sv
// EX/MEM register, word-addressed data memory, branch resolve and
// MEM/WB register. One instruction per cycle, no stall.
module ex_mem_wb_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    ex_mem_wb_stage_if.slave    ex,
    output logic                pc_src,
    output logic [31:0]         pc_target,
    output logic [31:0]         wb_data,
    output logic [4:0]          wb_reg,
    output logic                wb_reg_write,
    output logic                addr_err
);

    logic              mem_valid_q;
    logic              branch_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              reg_write_q;
    logic              mem_to_reg_q;
    logic              zero_q;
    logic [31:0]       pc_branch_q;
    logic [31:0]       alu_res_q;
    logic [4:0]        write_reg_q;
    logic [31:0]       rt_data_q;

    logic [31:0]       mem [DEPTH];

    logic              mem_valid;
    logic [ADDR_W-1:0] word_idx;
    logic              misaligned;
    logic              bad_access;
    logic [31:0]       rd_word;

    assign mem_valid  = ex.ex_valid & ~ex.flush;
    assign word_idx   = alu_res_q[ADDR_W+1:2];
    assign misaligned = alu_res_q[1:0] != 2'b00;
    assign bad_access = misaligned & (mem_read_q | mem_write_q);
    assign rd_word    = mem[word_idx];
    assign pc_src     = branch_q & zero_q & mem_valid_q;
    assign pc_target  = pc_branch_q;

    // EX/MEM latch; a squashed or empty slot carries no control bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q  <= 1'b0;
            branch_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            zero_q       <= 1'b0;
            pc_branch_q  <= '0;
            alu_res_q    <= '0;
            write_reg_q  <= '0;
            rt_data_q    <= '0;
        end else begin
            mem_valid_q  <= mem_valid;
            branch_q     <= ex.branch    & mem_valid;
            mem_read_q   <= ex.mem_read  & mem_valid;
            mem_write_q  <= ex.mem_write & mem_valid;
            reg_write_q  <= ex.reg_write & mem_valid;
            mem_to_reg_q <= ex.mem_to_reg;
            zero_q       <= ex.alu_zero;
            pc_branch_q  <= ex.pc_branch;
            alu_res_q    <= ex.alu_res;
            write_reg_q  <= ex.write_reg;
            rt_data_q    <= ex.rt_data;
        end
    end

    // Data memory store; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_write_q & ~misaligned)
            mem[word_idx] <= rt_data_q;
    end

    // MEM/WB latch; a faulting access is dropped and flagged instead
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_data      <= '0;
            wb_reg       <= '0;
            wb_reg_write <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            wb_data      <= mem_to_reg_q ? rd_word : alu_res_q;
            wb_reg       <= write_reg_q;
            wb_reg_write <= reg_write_q & ~bad_access;
            addr_err     <= bad_access;
        end
    end

endmodule

// File: doc/ex_mem_wb_stage.md
Name: ex_mem_wb_stage

Overview:
- Consumer of the execute stage's outputs: EX/MEM pipeline register, word-addressed data memory, branch resolution, and MEM/WB pipeline register in one block.
- Latches the ALU result, zero flag, branch target, destination register and store data from execute.
- Performs the load/store, drives the PC-select back to fetch, and presents write-back data and destination to the register file.

Parameters:
- DEPTH, 256, number of 32-bit words in data memory.
- ADDR_W, 8, word-address width; log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  execute-stage outputs carry a live instruction this cycle.
- flush  input  1  squash the instruction being latched into EX/MEM this edge.
- pc_branch  input  32  branch target from execute.
- alu_zero  input  1  ALU zero flag from execute.
- alu_res  input  32  ALU result; byte address for loads/stores.
- write_reg  input  5  destination register from execute.
- rt_data  input  32  store data.
- branch  input  1  instruction is BEQ.
- mem_read  input  1  instruction is LW.
- mem_write  input  1  instruction is SW.
- reg_write  input  1  instruction writes the register file.
- mem_to_reg  input  1  write-back source: 1 = memory, 0 = ALU.
- pc_src  output  1  take branch; fetch selects pc_target.
- pc_target  output  32  registered branch target.
- wb_data  output  32  write-back data.
- wb_reg  output  5  write-back destination.
- wb_reg_write  output  1  register-file write enable.
- addr_err  output  1  one-cycle flag: misaligned load/store reached MEM.

Behaviour:
- Reset asserted (async): EX/MEM and MEM/WB registers clear immediately. pc_src = 0, pc_target = 0, wb_data = 0, wb_reg = 0, wb_reg_write = 0, addr_err = 0.
- Memory array is not reset; contents persist across reset.
- Reset deasserting mid-flight: no instruction in progress survives.
- EX/MEM latch (edge ending cycle N):
  - All execute inputs are captured.
  - mem_valid = ex_valid & ~flush.
  - When mem_valid = 0, every stored control bit (branch, mem_read, mem_write, reg_write) is forced 0.
- MEM phase (cycle N+1), combinational from EX/MEM:
  - pc_src = mem_branch & mem_zero & mem_valid.
  - pc_target = EX/MEM pc_branch.
  - Word index = alu_res_q[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
  - Misaligned = alu_res_q[1:0] != 0.
  - Load read data is asynchronous from the array.
- Memory write at the edge ending N+1: only when mem_write_q & ~misaligned.
- mem_read_q and mem_write_q both set: write is performed; read data is the pre-write word.
- MEM/WB latch (edge ending N+1):
  - wb_data = mem_to_reg_q ? read word : alu_res_q.
  - wb_reg = write_reg_q.
  - wb_reg_write = reg_write_q & ~(misaligned & (mem_read_q | mem_write_q)).
  - addr_err = misaligned & (mem_read_q | mem_write_q).
- Latency: instruction presented at execute outputs in cycle N → pc_src valid in N+1 → wb_* valid in N+2.
- Throughput: one instruction per cycle; no stall.
- Register-file write targeting $0: this block passes it through; the register file discards it.
- Store followed by load to the same address in consecutive cycles: the load (MEM in N+2) reads the value written at the edge ending N+1. No forwarding needed.
- flush together with ex_valid = 1: instruction becomes a bubble; no memory write, no wb_reg_write, no pc_src.
- pc_src from an earlier branch does not itself flush; the hazard unit drives flush.

Test Plan:
- Reset mid-stream:
  - SW in EX/MEM, reset pulsed before the clock edge → no memory write.
  - All outputs 0 immediately.
  - After release, wb_reg_write stays 0 until a new instruction arrives.
- Store then load:
  - SW alu_res = 0x10, rt_data = 0xDEADBEEF, then LW alu_res = 0x10, write_reg = 9, mem_to_reg = 1.
  - Two cycles after the LW: wb_data = 0xDEADBEEF, wb_reg = 9, wb_reg_write = 1.
- Branch resolution:
  - branch = 1, alu_zero = 1, pc_branch = 0x40 → next cycle pc_src = 1, pc_target = 0x40.
  - Same with alu_zero = 0 → pc_src = 0.
- R-type write-back: alu_res = 0x1234, write_reg = 5, reg_write = 1, mem_to_reg = 0 → wb_data = 0x1234, wb_reg = 5 at N+2.
- Misaligned store:
  - SW alu_res = 0x13 → addr_err = 1 for exactly one cycle.
  - Word 4 is unchanged on read-back; wb_reg_write = 0.
- Flush and wrap:
  - SW with flush = 1 → no write, no addr_err.
  - SW to 0x400 (DEPTH = 256), then LW from 0x000 → returns the stored value.
